// File: rtl/eth_frame_filter.sv
// Byte-wide Ethernet II receive filter: buffers the L2 header, decides pass/drop from
// destination MAC and EtherType, then replays the header and cuts the body through.
module eth_frame_filter #(
  parameter int HDR_BYTES = 14,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_enable,
  input  logic             cfg_promisc,
  input  logic [47:0]      cfg_mac,
  input  logic [15:0]      cfg_block_type,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int               IDX_W    = $clog2(HDR_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_BYTES - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DECIDE,
    S_FWD_HDR,
    S_FWD_BODY,
    S_DROP
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             hdr_only, hdr_only_nxt;
  logic [7:0]       hdr_buf [HDR_BYTES];
  logic             buf_we;
  logic [IDX_W-1:0] buf_wa;
  logic             pass_inc;
  logic [1:0]       drop_inc;
  logic [47:0]      dst_mac;
  logic [15:0]      eth_type;
  logic             pass_dec;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  assign dst_mac  = {hdr_buf[0], hdr_buf[1], hdr_buf[2], hdr_buf[3], hdr_buf[4], hdr_buf[5]};
  assign eth_type = {hdr_buf[12], hdr_buf[13]};

  // Configuration is only consulted while in DECIDE, so mid-frame changes cannot split a frame.
  assign pass_dec = !cfg_enable ||
                    ((cfg_promisc || (dst_mac == cfg_mac) || (dst_mac == 48'hFFFF_FFFF_FFFF)) &&
                     ((cfg_block_type == 16'h0000) || (eth_type != cfg_block_type)));

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    hdr_only_nxt = hdr_only;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_sop      = 1'b0;
    out_eop      = 1'b0;
    out_data     = 8'h00;
    buf_we       = 1'b0;
    buf_wa       = idx;
    pass_inc     = 1'b0;
    drop_inc     = 2'd0;

    case (state)
      S_IDLE: begin
        // Async reset holds state in IDLE, so gating here keeps in_ready low during reset.
        in_ready = reset_n;
        if (in_valid && reset_n && in_sop) begin
          buf_we = 1'b1;
          buf_wa = '0;
          if (in_eop) begin
            drop_inc = 2'd1;
          end else begin
            state_nxt = S_HDR;
            idx_nxt   = ONE_IDX;
          end
        end
      end

      S_HDR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_we = 1'b1;
          if (in_sop) begin
            // Abandon the partial frame and restart; a sop+eop byte is also a runt of its own.
            buf_wa = '0;
            if (in_eop) begin
              drop_inc  = 2'd2;
              state_nxt = S_IDLE;
            end else begin
              drop_inc = 2'd1;
              idx_nxt  = ONE_IDX;
            end
          end else if (idx == LAST_IDX) begin
            state_nxt    = S_DECIDE;
            hdr_only_nxt = in_eop;
          end else if (in_eop) begin
            drop_inc  = 2'd1;
            state_nxt = S_IDLE;
          end else begin
            idx_nxt = idx + ONE_IDX;
          end
        end
      end

      S_DECIDE: begin
        if (pass_dec) begin
          state_nxt = S_FWD_HDR;
          idx_nxt   = '0;
        end else if (hdr_only) begin
          drop_inc  = 2'd1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DROP;
        end
      end

      S_FWD_HDR: begin
        out_valid = 1'b1;
        out_data  = hdr_buf[idx];
        out_sop   = (idx == '0);
        out_eop   = hdr_only && (idx == LAST_IDX);
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            if (hdr_only) begin
              pass_inc  = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              state_nxt = S_FWD_BODY;
            end
          end else begin
            idx_nxt = idx + ONE_IDX;
          end
        end
      end

      S_FWD_BODY: begin
        out_data  = in_data;
        out_valid = in_valid;
        out_eop   = in_eop;
        in_ready  = out_ready;
        if (in_valid && out_ready && in_eop) begin
          pass_inc  = 1'b1;
          state_nxt = S_IDLE;
        end
      end

      S_DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_eop) begin
          drop_inc  = 2'd1;
          state_nxt = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      hdr_only   <= 1'b0;
      pass_count <= '0;
      drop_count <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      hdr_only <= hdr_only_nxt;
      if (pass_inc)
        pass_count <= sat_add(pass_count, 2'd1);
      if (drop_inc != 2'd0)
        drop_count <= sat_add(drop_count, drop_inc);
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we)
      hdr_buf[buf_wa] <= in_data;
  end

endmodule

// File: tb/tb_eth_frame_filter.sv
// Directed bench for eth_frame_filter: pass/drop filtering, runts, backpressure,
// counter saturation and mid-frame reset.
module tb_eth_frame_filter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cfg_enable = 1'b1;
  logic        cfg_promisc = 1'b0;
  logic [47:0] cfg_mac = 48'h0200_0000_0001;
  logic [15:0] cfg_block_type = 16'h0000;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_sop, out_eop;
  logic        out_ready = 1'b1;
  logic [15:0] pass_count, drop_count;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          bp_en = 1'b0;
  bit          drop_win = 1'b0;
  int          leak = 0;
  logic [9:0]  outq[$];
  int          sop_edges[$];
  logic [7:0]  fb [0:255];
  bit          stall_prev = 1'b0;
  logic [9:0]  prev_word = 10'h000;
  int          hdr_edge = 0;
  int          exp_pass = 0;
  int          exp_drop = 0;

  eth_frame_filter #(.HDR_BYTES(14), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_enable(cfg_enable), .cfg_promisc(cfg_promisc),
    .cfg_mac(cfg_mac), .cfg_block_type(cfg_block_type),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_ready(out_ready),
    .pass_count(pass_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Egress monitor: records transfers due at the next edge and checks hold-while-stalled.
  always @(negedge clk) begin
    if (stall_prev) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_hold", 32'({out_sop, out_eop, out_data}), 32'(prev_word));
    end
    if (out_valid && out_ready) begin
      outq.push_back({out_sop, out_eop, out_data});
      if (out_sop) sop_edges.push_back(cyc + 1);
    end
    if (drop_win && out_valid) leak++;
    stall_prev = out_valid && !out_ready && reset_n;
    prev_word  = {out_sop, out_eop, out_data};
  end

  task automatic build_frame(input logic [47:0] dst, input logic [15:0] typ,
                             input int len, input int seed);
    for (int i = 0; i < len; i++) begin
      if (i < 6)        fb[i] = dst[47 - 8*i -: 8];
      else if (i < 12)  fb[i] = 8'(8'h10 + i);
      else if (i == 12) fb[i] = typ[15:8];
      else if (i == 13) fb[i] = typ[7:0];
      else              fb[i] = 8'(seed + i * 13);
    end
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic s, input logic e, input bit chk_cut);
    int waited = 0;
    bit acc = 1'b0;
    in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      if (chk_cut) check("cut_ready", 32'(in_ready), 32'(out_ready));
      @(posedge clk); #1;
      waited++;
      if (!acc && waited > 500) begin
        n_checks++;
        n_errors++;
        $error("FAIL in_ready_timeout: observed no accept in %0d cycles, expected accept", waited);
        acc = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int len, input bit chk_cut);
    for (int i = 0; i < len; i++) begin
      drive_byte(fb[i], i == 0, i == len - 1, chk_cut && (i >= 15));
      if (i == 13) hdr_edge = cyc;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input int len);
    int bad = 0;
    logic [9:0] w;
    check({tag, "_len"}, 32'(outq.size()), 32'(len));
    for (int i = 0; i < outq.size() && i < len; i++) begin
      w = {1'(i == 0), 1'(i == len - 1), fb[i]};
      if (outq[i] !== w) bad++;
    end
    check({tag, "_bytes"}, 32'(bad), 32'd0);
    outq.delete();
    sop_edges.delete();
  endtask

  initial begin
    // Reset
    #2 reset_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_pass", 32'(pass_count), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Unicast pass
    build_frame(48'h0200_0000_0001, 16'h0800, 64, 3);
    outq.delete(); sop_edges.delete();
    send_frame(64, 1'b0);
    idle(20);
    check("uni_latency", (sop_edges.size() > 0) ? 32'(sop_edges[0] - hdr_edge) : 32'hFFFF_FFFF, 32'd2);
    expect_frame("uni", 64);
    exp_pass++;
    check("uni_pass", 32'(pass_count), 32'(exp_pass));
    check("uni_drop", 32'(drop_count), 32'(exp_drop));

    // Filtering: wrong MAC dropped, broadcast header-only passed, blocked type dropped
    drop_win = 1'b1;
    build_frame(48'h0200_0000_0002, 16'h0800, 40, 5);
    send_frame(40, 1'b0);
    idle(3);
    drop_win = 1'b0;
    exp_drop++;
    build_frame(48'hFFFF_FFFF_FFFF, 16'h0800, 14, 7);
    send_frame(14, 1'b0);
    idle(20);
    expect_frame("bcast", 14);
    exp_pass++;
    cfg_block_type = 16'h86DD;
    drop_win = 1'b1;
    build_frame(48'h0200_0000_0001, 16'h86DD, 30, 11);
    send_frame(30, 1'b0);
    idle(3);
    exp_drop++;
    check("filt_pass", 32'(pass_count), 32'(exp_pass));
    check("filt_drop", 32'(drop_count), 32'(exp_drop));

    // Runts: 10-byte frame, lone sop+eop byte, and a frame restarted by a new sop
    build_frame(48'h0200_0000_0001, 16'h0800, 10, 13);
    send_frame(10, 1'b0);
    exp_drop++;
    drive_byte(8'h55, 1'b1, 1'b1, 1'b0);
    idle(2);
    exp_drop++;
    for (int i = 0; i < 5; i++) drive_byte(8'(8'hC0 + i), i == 0, 1'b0, 1'b0);
    drop_win = 1'b0;
    check("drop_no_output", 32'(leak), 32'd0);
    build_frame(48'h0200_0000_0001, 16'h0800, 20, 17);
    outq.delete(); sop_edges.delete();
    send_frame(20, 1'b0);
    idle(20);
    expect_frame("restart", 20);
    exp_drop++;
    exp_pass++;
    check("runt_drop", 32'(drop_count), 32'(exp_drop));
    check("runt_pass", 32'(pass_count), 32'(exp_pass));

    // Backpressure on a 100-byte passed frame
    build_frame(48'h0200_0000_0001, 16'h0800, 100, 19);
    bp_en = 1'b1;
    send_frame(100, 1'b1);
    bp_en = 1'b0;
    idle(20);
    expect_frame("bp", 100);
    exp_pass++;
    check("bp_pass", 32'(pass_count), 32'(exp_pass));

    // Saturation: one dropped runt per cycle up to 0xFFFE, then past the ceiling
    in_data = 8'hAA; in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1;
    repeat (65534 - exp_drop) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("sat_below", 32'(drop_count), 32'hFFFE);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    check("sat_hold", 32'(drop_count), 32'hFFFF);
    check("sat_pass", 32'(pass_count), 32'(exp_pass));

    // Reset asserted mid-body
    build_frame(48'h0200_0000_0001, 16'h0800, 40, 23);
    for (int i = 0; i < 26; i++) drive_byte(fb[i], i == 0, 1'b0, 1'b0);
    in_data = fb[26]; in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    check("body_cut_valid", 32'(out_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sop_eop", 32'({out_sop, out_eop}), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_pass", 32'(pass_count), 32'd0);
    check("mid_rst_drop", 32'(drop_count), 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    exp_pass = 0;
    exp_drop = 0;
    @(posedge clk); #1;
    outq.delete(); sop_edges.delete();
    build_frame(48'h0200_0000_0001, 16'h0800, 30, 29);
    send_frame(30, 1'b0);
    idle(20);
    expect_frame("post_rst", 30);
    exp_pass++;
    check("post_rst_pass", 32'(pass_count), 32'(exp_pass));
    check("post_rst_drop", 32'(drop_count), 32'(exp_drop));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eth_frame_filter.md
# eth_frame_filter

- Byte-wide Ethernet frame filter that sits inside `soc_system` in the receive path, directly upstream of the HPS-facing stream sink.
- Captures the 14-byte L2 header of each frame, decides pass or drop from destination MAC and EtherType against configuration inputs, then either replays the header and cuts the body through, or discards the whole frame.
- Keeps saturating pass and drop counters for software readout.

## Interface
Parameters:
- `HDR_BYTES`, 14: header bytes captured before the decision; fixed for Ethernet II.
- `CNT_W`, 16: width of the pass and drop counters.

Ports:
- `clk`  in  1  system clock (driven from `clk_clk`)
- `reset_n`  in  1  reset; asynchronous, active-low (driven from `reset_reset_n`)
- `cfg_enable`  in  1  0: every complete frame passes unfiltered
- `cfg_promisc`  in  1  1: destination MAC check is skipped
- `cfg_mac`  in  48  station MAC; byte 0 of the frame maps to [47:40]
- `cfg_block_type`  in  16  EtherType to drop; 16'h0000 disables this check
- `in_data`  in  8  ingress byte
- `in_valid`, `in_sop`, `in_eop`  in  1 each  ingress valid, start-of-packet, end-of-packet
- `in_ready`  out  1  ingress ready
- `out_data`  out  8  egress byte
- `out_valid`, `out_sop`, `out_eop`  out  1 each  egress valid, start-of-packet, end-of-packet
- `out_ready`  in  1  egress ready
- `pass_count`, `drop_count`  out  CNT_W each  frames forwarded / frames discarded; both saturate

## Operation
- **Transfer rule.** A transfer occurs on an edge where valid and ready are both 1, on both sides. Egress data and sideband stay stable while `out_valid`=1 and `out_ready`=0.
- **States.** IDLE, HDR, DECIDE, FWD_HDR, FWD_BODY, DROP.
- **IDLE.**
  - `in_ready`=1.
  - A byte without `in_sop` is discarded and not counted.
  - A byte with `in_sop` is stored at buffer index 0; next state is HDR.
  - If that byte also has `in_eop`: counted as a runt, `drop_count`+1, stay in IDLE.
- **HDR.**
  - `in_ready`=1; bytes are stored at indices 1..13.
  - `in_sop` on an accepted byte: the partial frame is counted as a drop and collection restarts at index 0 with this byte.
  - `in_eop` before index 13: runt, `drop_count`+1, go to IDLE.
  - Index 13 accepted: go to DECIDE. Latch whether that byte carried `eop` (header-only frame).
- **DECIDE** (exactly 1 cycle, `in_ready`=0).
  - Configuration inputs are sampled here.
  - `pass` = !`cfg_enable` | ((`cfg_promisc` | dst==`cfg_mac` | dst==48'hFFFF_FFFF_FFFF) & (`cfg_block_type`==0 | type!=`cfg_block_type`)).
  - dst = bytes 0..5; type = {byte12, byte13}.
  - pass: go to FWD_HDR.
  - drop, header-only frame: `drop_count`+1, go to IDLE.
  - drop, otherwise: go to DROP.
- **FWD_HDR.**
  - `in_ready`=0; `out_valid`=1 with buffered bytes 0..13.
  - `out_sop`=1 on byte 0.
  - `out_eop`=1 on byte 13 only for a header-only frame.
  - After byte 13 transfers: `pass_count`+1 and go to IDLE if header-only, else go to FWD_BODY.
- **FWD_BODY.**
  - Combinational cut-through: `out_data`=`in_data`, `out_valid`=`in_valid`, `out_eop`=`in_eop`, `out_sop`=0, `in_ready`=`out_ready`.
  - `in_sop` is ignored here.
  - Transfer with `eop`: `pass_count`+1, go to IDLE.
- **DROP.**
  - `in_ready`=1; accepted bytes are discarded.
  - `in_eop` accepted: `drop_count`+1, go to IDLE.
- **Counters.** Increment at most once per frame and hold at all-ones.

## Timing
- **Reset values.** State IDLE; `in_ready`=0 while `reset_n`=0, then 1 in IDLE; `out_valid`=`out_sop`=`out_eop`=0; `out_data`=0; both counters 0. Buffer contents are don't-care.
- **Reset mid-frame.** Abort immediately, emit nothing further, count nothing.
- **Latency.** The 14th header byte is accepted at edge k. DECIDE occupies cycle k+1. Egress byte 0 with `sop` is valid in cycle k+2.
- **Throughput.**
  - Header replay runs at 1 byte/cycle when `out_ready`=1.
  - The body adds no latency.
  - Per passed frame, one bubble cycle (DECIDE) plus 14 cycles of `in_ready`=0 during FWD_HDR.
- **Back-to-back frames.** After `eop` the block is in IDLE on the next cycle and accepts the next `sop` immediately.

## Test plan
- **Unicast pass.** `cfg_enable`=1, `cfg_mac`=02:00:00:00:00:01, 64-byte frame to that MAC with type 0x0800, `out_ready`=1.
  - Required: 64 identical bytes out, `sop` on byte 0, `eop` on byte 63, first output 2 cycles after the 14th input, `pass_count`=1.
- **Filtering.**
  - Frame to 02:00:00:00:00:02 is dropped.
  - Broadcast frame is passed.
  - With `cfg_block_type`=0x86DD, a frame to `cfg_mac` with type 0x86DD is dropped.
  - Required: `pass_count`=1, `drop_count`=2; no `out_valid` during the dropped frames.
- **Runts.**
  - 10-byte frame, a single byte with `sop`+`eop`, and a frame with a new `sop` at byte 5.
  - Required: `drop_count`=3; the restarted frame (20 bytes, matching) passes intact.
- **Backpressure.** Toggle `out_ready` pseudo-randomly during a 100-byte passed frame.
  - Required: output stable while stalled, no byte lost or duplicated, `in_ready` follows `out_ready` in FWD_BODY.
- **Saturation and reset.**
  - Preload via 65536 dropped runts: `drop_count` stays 0xFFFF.
  - Assert `reset_n`=0 mid-body: all outputs and counters return to 0, and the next frame is processed normally.
